// File: rtl/fifo_packetizer.sv
// fifo_packetizer: drains fixed-length packets from an upstream FIFO and emits
// them as a header beat followed by PKT_LEN payload beats on a valid/ready stream.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   en_i                 packet-start enable, sampled only in IDLE
//   fifo_usedw_i         upstream FIFO fill level
//   fifo_empty_i         upstream FIFO empty flag
//   fifo_rd_req_o        FIFO read strobe; fifo_data_i is valid one cycle later
//   fifo_data_i          FIFO read data
//   tx_data_o            output beat ({4'hA, seq} for the header, FIFO word otherwise)
//   tx_valid_o/ready_i   beat handshake; transfer when both are high
//   tx_sop_o, tx_eop_o   first / last beat of a packet
//   pkt_count_o          completed packets, wraps at 2^16
//   busy_o               high whenever the FSM is outside IDLE
module fifo_packetizer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 10,
  parameter int PKT_LEN    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [ADDR_BITS-1:0]  fifo_usedw_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_req_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_valid_o,
  output logic                  tx_sop_o,
  output logic                  tx_eop_o,
  input  logic                  tx_ready_i,
  output logic [15:0]           pkt_count_o,
  output logic                  busy_o
);
  localparam int SW = DATA_WIDTH - 4;
  localparam logic [ADDR_BITS-1:0] LEN  = ADDR_BITS'(PKT_LEN);
  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(PKT_LEN - 1);
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  rd_cnt_q, rd_cnt_d, beat_q, beat_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]            cnt_q, cnt_d, kept;
  logic                  inflight_q;
  logic [SW-1:0]         seq_q, seq_d;
  logic [15:0]           pkt_q, pkt_d;
  logic                  start, pop, eop_xfer;
  // buf0 is always the head of the 2-entry payload buffer; inflight_q marks a
  // read issued last cycle whose data is on fifo_data_i now.
  // busy follows the FSM, so it stays high across payload gaps.
  always_comb begin
    tx_valid_o    = state_q == HDR || (state_q == PAY && cnt_q != 2'd0);
    tx_sop_o      = state_q == HDR;
    tx_eop_o      = state_q == PAY && cnt_q != 2'd0 && beat_q == LAST;
    tx_data_o     = state_q == HDR ? {4'hA, seq_q} : tx_valid_o ? buf0_q : '0;
    busy_o        = state_q != IDLE;
    start         = state_q == IDLE && en_i && fifo_usedw_i >= LEN;
    pop           = state_q == PAY && cnt_q != 2'd0 && tx_ready_i;
    eop_xfer      = pop && tx_eop_o;
    // a read is allowed while fewer than two words are held or owed, or when a
    // beat leaves this cycle so the total cannot grow past two
    fifo_rd_req_o = state_q != IDLE && rd_cnt_q != '0 && !fifo_empty_i &&
                    (({1'b0, cnt_q} + {2'b0, inflight_q}) < 3'd2 || pop);
    state_d       = start ? HDR : (state_q == HDR && tx_ready_i) ? PAY : eop_xfer ? IDLE : state_q;
    rd_cnt_d      = start ? LEN : rd_cnt_q - ADDR_BITS'(fifo_rd_req_o);
    beat_d        = start ? '0 : beat_q + ADDR_BITS'(pop);
    seq_d         = seq_q + SW'(eop_xfer);
    pkt_d         = pkt_q + 16'(eop_xfer);
    kept          = cnt_q - 2'(pop);
    buf0_d        = inflight_q && kept == 2'd0 ? fifo_data_i : pop ? buf1_q : buf0_q;
    buf1_d        = inflight_q && kept != 2'd0 ? fifo_data_i : buf1_q;
    cnt_d         = kept + 2'(inflight_q);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      beat_q     <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      seq_q      <= '0;
      pkt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      beat_q     <= beat_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      cnt_q      <= cnt_d;
      inflight_q <= fifo_rd_req_o;
      seq_q      <= seq_d;
      pkt_q      <= pkt_d;
    end
  end
  assign pkt_count_o = pkt_q;
endmodule
